// File: rtl/enemy_array_control.sv
// enemy_array_control: steps up to NUM_ENEMIES square enemies on a shared
// rate-divided tick, bounces them off the screen edges, accepts spawns into
// the lowest free slot and flags overlaps with the player.
// Optional feature macro: ENEMY_KILL_ON_HIT_EN (a colliding enemy is removed).
module enemy_array_control #(
  parameter int NUM_ENEMIES = 4,
  parameter int RATE_DIV    = 249999,
  parameter int SCREEN_W    = 160,
  parameter int SCREEN_H    = 120,
  parameter int PLAYER_SIZE = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     play,
  input  logic [7:0]               playerX,
  input  logic [6:0]               playerY,
  input  logic                     spawn_valid,
  output logic                     spawn_ready,
  input  logic [2:0]               spawn_size,
  input  logic [7:0]               spawn_x,
  input  logic [6:0]               spawn_y,
  input  logic [2:0]               spawn_dx,
  input  logic [2:0]               spawn_dy,
  input  logic                     spawn_left,
  input  logic                     spawn_up,
  output logic [NUM_ENEMIES-1:0]   enemy_active,
  output logic [8*NUM_ENEMIES-1:0] enemyX,
  output logic [7*NUM_ENEMIES-1:0] enemyY,
  output logic                     tick,
  output logic [NUM_ENEMIES-1:0]   hit_mask,
  output logic                     player_hit
);

  localparam int              CNT_W   = (RATE_DIV > 0) ? $clog2(RATE_DIV + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RATE_DIV);
  localparam logic [8:0]      SW9     = 9'(SCREEN_W);
  localparam logic [8:0]      SH9     = 9'(SCREEN_H);
  localparam logic [8:0]      PS9     = 9'(PLAYER_SIZE);

  logic [CNT_W-1:0] r_cnt;
  logic             r_tick;
  logic             r_player_hit;
  logic             w_tick_fire;
  logic             w_accept;

  // Spawn values after size fix-up and on-screen clamping, shared by all slots
  logic [2:0] w_sp_size;
  logic [8:0] w_sp_size9;
  logic [8:0] w_sp_xmax;
  logic [8:0] w_sp_ymax;
  logic [7:0] w_sp_x;
  logic [6:0] w_sp_y;

  assign w_tick_fire = play & (r_cnt == CNT_MAX);
  assign spawn_ready = play & ~(&enemy_active);
  assign w_accept    = spawn_valid & spawn_ready;

  assign w_sp_size  = (spawn_size == 3'd0) ? 3'd1 : spawn_size;
  assign w_sp_size9 = {6'd0, w_sp_size};
  assign w_sp_xmax  = SW9 - w_sp_size9;
  assign w_sp_ymax  = SH9 - w_sp_size9;
  assign w_sp_x     = ({1'b0, spawn_x} > w_sp_xmax) ? 8'(w_sp_xmax) : spawn_x;
  assign w_sp_y     = ({2'b0, spawn_y} > w_sp_ymax) ? 7'(w_sp_ymax) : spawn_y;

  // Rate divider: runs only while playing, the wrap edge is the tick edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_tick_fire;
      if (play) begin
        r_cnt <= (r_cnt == CNT_MAX) ? '0 : r_cnt + CNT_W'(1);
      end
    end
  end

  // Registered OR of the sticky per-slot hit flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_player_hit <= 1'b0;
    end else begin
      r_player_hit <= |hit_mask;
    end
  end

  assign tick       = r_tick;
  assign player_hit = r_player_hit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ENEMIES; gi++) begin : g_slot
      // All slots below this one must be busy for this one to take a spawn
      localparam logic [NUM_ENEMIES-1:0] LOW_MASK = NUM_ENEMIES'((1 << gi) - 1);

      logic       r_active;
      logic       r_hit;
      logic       r_left;
      logic       r_up;
      logic [7:0] r_x;
      logic [6:0] r_y;
      logic [2:0] r_size;
      logic [2:0] r_dx;
      logic [2:0] r_dy;

      logic       w_sel;
      logic [8:0] w_x9;
      logic [8:0] w_y9;
      logic [8:0] w_size9;
      logic [8:0] w_dx9;
      logic [8:0] w_dy9;
      logic [8:0] w_px9;
      logic [8:0] w_py9;
      logic [7:0] w_nx;
      logic [6:0] w_ny;
      logic       w_nleft;
      logic       w_nup;
      logic       w_overlap;

      assign w_sel   = w_accept & ~r_active & ((enemy_active & LOW_MASK) == LOW_MASK);
      assign w_x9    = {1'b0, r_x};
      assign w_y9    = {2'b0, r_y};
      assign w_size9 = {6'd0, r_size};
      assign w_dx9   = {6'd0, r_dx};
      assign w_dy9   = {6'd0, r_dy};
      assign w_px9   = {1'b0, playerX};
      assign w_py9   = {2'b0, playerY};

      // Next X position and direction on a tick, bouncing at the screen edges
      always_comb begin
        w_nx    = r_x;
        w_nleft = r_left;
        if (r_dx != 3'd0) begin
          if (r_left) begin
            if (w_x9 <= w_dx9) begin
              w_nx    = 8'd0;
              w_nleft = 1'b0;
            end else begin
              w_nx = 8'(w_x9 - w_dx9);
            end
          end else if (w_x9 + w_size9 + w_dx9 >= SW9) begin
            w_nx    = 8'(SW9 - w_size9);
            w_nleft = 1'b1;
          end else begin
            w_nx = 8'(w_x9 + w_dx9);
          end
        end
      end

      // Next Y position and direction on a tick, same rules against the height
      always_comb begin
        w_ny  = r_y;
        w_nup = r_up;
        if (r_dy != 3'd0) begin
          if (r_up) begin
            if (w_y9 <= w_dy9) begin
              w_ny  = 7'd0;
              w_nup = 1'b0;
            end else begin
              w_ny = 7'(w_y9 - w_dy9);
            end
          end else if (w_y9 + w_size9 + w_dy9 >= SH9) begin
            w_ny  = 7'(SH9 - w_size9);
            w_nup = 1'b1;
          end else begin
            w_ny = 7'(w_y9 + w_dy9);
          end
        end
      end

      assign w_overlap = r_active
                       & (w_px9 <= w_x9 + w_size9 - 9'd1)
                       & (w_x9 <= w_px9 + PS9 - 9'd1)
                       & (w_py9 <= w_y9 + w_size9 - 9'd1)
                       & (w_y9 <= w_py9 + PS9 - 9'd1);

      // Slot state: a spawn overrides stepping; hits are sticky until respawn
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_active <= 1'b0;
          r_hit    <= 1'b0;
          r_left   <= 1'b0;
          r_up     <= 1'b0;
          r_x      <= 8'd0;
          r_y      <= 7'd0;
          r_size   <= 3'd0;
          r_dx     <= 3'd0;
          r_dy     <= 3'd0;
        end else if (w_sel) begin
          r_active <= 1'b1;
          r_hit    <= 1'b0;
          r_left   <= spawn_left;
          r_up     <= spawn_up;
          r_x      <= w_sp_x;
          r_y      <= w_sp_y;
          r_size   <= w_sp_size;
          r_dx     <= spawn_dx;
          r_dy     <= spawn_dy;
        end else begin
          if (w_tick_fire && r_active) begin
            r_x    <= w_nx;
            r_y    <= w_ny;
            r_left <= w_nleft;
            r_up   <= w_nup;
          end
          if (play && w_overlap) begin
            r_hit <= 1'b1;
`ifdef ENEMY_KILL_ON_HIT_EN
            r_active <= 1'b0;
`endif
          end
        end
      end

      assign enemy_active[gi]   = r_active;
      assign hit_mask[gi]       = r_hit;
      assign enemyX[8*gi +: 8]  = r_x;
      assign enemyY[7*gi +: 7]  = r_y;
    end
  endgenerate

endmodule

// File: tb/tb_enemy_array_control.sv
// tb_enemy_array_control: directed scenarios with hand-computed values plus
// randomized play, compared every cycle against a behavioural slot model.
module tb_enemy_array_control;
  localparam int N  = 4;
  localparam int RD = 3;
  localparam int SW = 160;
  localparam int SH = 120;
  localparam int PS = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic         play;
  logic [7:0]   playerX;
  logic [6:0]   playerY;
  logic         spawn_valid;
  logic         spawn_ready;
  logic [2:0]   spawn_size;
  logic [7:0]   spawn_x;
  logic [6:0]   spawn_y;
  logic [2:0]   spawn_dx;
  logic [2:0]   spawn_dy;
  logic         spawn_left;
  logic         spawn_up;
  logic [N-1:0] enemy_active;
  logic [8*N-1:0] enemyX;
  logic [7*N-1:0] enemyY;
  logic         tick;
  logic [N-1:0] hit_mask;
  logic         player_hit;

  enemy_array_control #(
    .NUM_ENEMIES(N), .RATE_DIV(RD), .SCREEN_W(SW), .SCREEN_H(SH), .PLAYER_SIZE(PS)
  ) dut (
    .clk(clk), .reset(reset), .play(play), .playerX(playerX), .playerY(playerY),
    .spawn_valid(spawn_valid), .spawn_ready(spawn_ready), .spawn_size(spawn_size),
    .spawn_x(spawn_x), .spawn_y(spawn_y), .spawn_dx(spawn_dx), .spawn_dy(spawn_dy),
    .spawn_left(spawn_left), .spawn_up(spawn_up), .enemy_active(enemy_active),
    .enemyX(enemyX), .enemyY(enemyY), .tick(tick), .hit_mask(hit_mask),
    .player_hit(player_hit)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_cnt;
  bit m_tick, m_ph;
  bit m_act [N];
  bit m_hit [N];
  bit m_neg_x [N];
  bit m_neg_y [N];
  int m_x [N];
  int m_y [N];
  int m_sz [N];
  int m_dx [N];
  int m_dy [N];

  function automatic int new_pos(int p, bit neg, int d, int sz, int lim);
    if (d == 0) return p;
    if (neg) return (p <= d) ? 0 : p - d;
    return (p + sz + d >= lim) ? lim - sz : p + d;
  endfunction

  function automatic bit new_dir(int p, bit neg, int d, int sz, int lim);
    if (d == 0) return neg;
    if (neg) return !(p <= d);
    return (p + sz + d >= lim);
  endfunction

  function automatic int size_of(int s);
    return (s == 0) ? 1 : s;
  endfunction

  function automatic int clamp(int v, int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic int first_free();
    for (int i = 0; i < N; i++) if (!m_act[i]) return i;
    return -1;
  endfunction

  function automatic bit overlaps(int i);
    int px, py;
    px = int'(playerX);
    py = int'(playerY);
    return m_act[i] && (px <= m_x[i] + m_sz[i] - 1) && (m_x[i] <= px + PS - 1)
                    && (py <= m_y[i] + m_sz[i] - 1) && (m_y[i] <= py + PS - 1);
  endfunction

  function automatic bit any_hit();
    for (int i = 0; i < N; i++) if (m_hit[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [63:0] exp_act();
    logic [63:0] v = '0;
    for (int i = 0; i < N; i++) v[i] = m_act[i];
    return v;
  endfunction

  function automatic logic [63:0] exp_hit();
    logic [63:0] v = '0;
    for (int i = 0; i < N; i++) v[i] = m_hit[i];
    return v;
  endfunction

  function automatic logic [63:0] exp_x();
    logic [63:0] v = '0;
    for (int i = 0; i < N; i++) v[8*i +: 8] = 8'(m_x[i]);
    return v;
  endfunction

  function automatic logic [63:0] exp_y();
    logic [63:0] v = '0;
    for (int i = 0; i < N; i++) v[7*i +: 7] = 7'(m_y[i]);
    return v;
  endfunction

  // Model state advances on the same edges as the DUT
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cnt  <= 0;
      m_tick <= 1'b0;
      m_ph   <= 1'b0;
      for (int i = 0; i < N; i++) begin
        m_act[i] <= 1'b0; m_hit[i] <= 1'b0; m_neg_x[i] <= 1'b0; m_neg_y[i] <= 1'b0;
        m_x[i] <= 0; m_y[i] <= 0; m_sz[i] <= 0; m_dx[i] <= 0; m_dy[i] <= 0;
      end
    end else begin
      m_tick <= play && (m_cnt == RD);
      if (play) m_cnt <= (m_cnt == RD) ? 0 : m_cnt + 1;
      m_ph <= any_hit();
      for (int i = 0; i < N; i++) begin
        if (play && spawn_valid && first_free() == i) begin
          m_act[i]   <= 1'b1;
          m_hit[i]   <= 1'b0;
          m_sz[i]    <= size_of(int'(spawn_size));
          m_x[i]     <= clamp(int'(spawn_x), SW - size_of(int'(spawn_size)));
          m_y[i]     <= clamp(int'(spawn_y), SH - size_of(int'(spawn_size)));
          m_dx[i]    <= int'(spawn_dx);
          m_dy[i]    <= int'(spawn_dy);
          m_neg_x[i] <= spawn_left;
          m_neg_y[i] <= spawn_up;
        end else begin
          if (play && m_cnt == RD && m_act[i]) begin
            m_x[i]     <= new_pos(m_x[i], m_neg_x[i], m_dx[i], m_sz[i], SW);
            m_neg_x[i] <= new_dir(m_x[i], m_neg_x[i], m_dx[i], m_sz[i], SW);
            m_y[i]     <= new_pos(m_y[i], m_neg_y[i], m_dy[i], m_sz[i], SH);
            m_neg_y[i] <= new_dir(m_y[i], m_neg_y[i], m_dy[i], m_sz[i], SH);
          end
          if (play && overlaps(i)) begin
            m_hit[i] <= 1'b1;
`ifdef ENEMY_KILL_ON_HIT_EN
            m_act[i] <= 1'b0;
`endif
          end
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cmp_active", enemy_active, exp_act());
      check("cmp_enemyX", enemyX, exp_x());
      check("cmp_enemyY", enemyY, exp_y());
      check("cmp_tick", tick, m_tick);
      check("cmp_hit_mask", hit_mask, exp_hit());
      check("cmp_player_hit", player_hit, m_ph);
      check("cmp_spawn_ready", spawn_ready, play && (first_free() >= 0));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_spawn(input int x, input int y, input int sz, input int dx,
                           input int dy, input bit left, input bit up);
    spawn_x = 8'(x); spawn_y = 7'(y); spawn_size = 3'(sz);
    spawn_dx = 3'(dx); spawn_dy = 3'(dy); spawn_left = left; spawn_up = up;
  endtask

  // Asynchronous reset in the middle of a cycle; outputs must clear at once
  task automatic do_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    play = 1'b0;
    spawn_valid = 1'b0;
    #1;
    check("reset_async_active", enemy_active, '0);
    check("reset_async_X", enemyX, '0);
    check("reset_async_Y", enemyY, '0);
    check("reset_async_tick", tick, 1'b0);
    check("reset_async_hit", hit_mask, '0);
    check("reset_async_player_hit", player_hit, 1'b0);
    @(negedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0; play = 1'b0; playerX = 8'd0; playerY = 7'd0; spawn_valid = 1'b0;
    set_spawn(0, 0, 0, 0, 0, 1'b0, 1'b0);
    #2 reset = 1'b1;
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    cmp_en = 1'b1;

    // Idle after reset: everything zero, no spawning while paused
    @(negedge clk);
    check("idle_active", enemy_active, '0);
    check("idle_ready_paused", spawn_ready, 1'b0);
    #1 play = 1'b1;
    #1 check("ready_playing", spawn_ready, 1'b1);
    // First tick lands on the 4th edge after play rises
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check($sformatf("first_tick_%0d", k), tick, (k == 4));
    end

    // Fill all slots with spawn_valid held; 5th request stalls
    do_reset();
    playerX = 8'd0; playerY = 7'd0;
    set_spawn(50, 50, 1, 0, 0, 1'b0, 1'b0);
    play = 1'b1; spawn_valid = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check($sformatf("fill_active_%0d", k), enemy_active, (k >= 4) ? 4'hF : 4'((1 << k) - 1));
    end
    check("fill_ready_full", spawn_ready, 1'b0);
    #1 spawn_valid = 1'b0; play = 1'b0;
    #1 check("fill_ready_paused", spawn_ready, 1'b0);

    // Left bounce: x=2 dx=3 size 2 -> 0 then 3
    do_reset();
    playerX = 8'd150; playerY = 7'd5;
    set_spawn(2, 60, 2, 3, 0, 1'b1, 1'b0);
    play = 1'b1; spawn_valid = 1'b1;
    @(negedge clk);
    check("left_spawn_x", enemyX[7:0], 8'd2);
    #1 spawn_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("left_tick1_x", enemyX[7:0], 8'd0);
    repeat (4) @(negedge clk);
    check("left_tick2_x", enemyX[7:0], 8'd3);

    // Right bounce on X (slot 0) and bottom bounce on Y (slot 1)
    do_reset();
    playerX = 8'd80; playerY = 7'd60;
    set_spawn(155, 10, 3, 4, 0, 1'b0, 1'b0);
    play = 1'b1; spawn_valid = 1'b1;
    @(negedge clk);
    #1 set_spawn(20, 116, 2, 0, 2, 1'b0, 1'b0);
    @(negedge clk);
    #1 spawn_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("right_tick1_x", enemyX[7:0], 8'd157);
    check("down_tick1_y", enemyY[13:7], 7'd118);
    repeat (4) @(negedge clk);
    check("right_tick2_x", enemyX[7:0], 8'd153);
    check("down_tick2_y", enemyY[13:7], 7'd116);

    // Collision: player (80,100), enemy size 2 at (82,102)
    do_reset();
    playerX = 8'd80; playerY = 7'd100;
    set_spawn(82, 102, 2, 0, 0, 1'b0, 1'b0);
    play = 1'b1; spawn_valid = 1'b1;
    @(negedge clk);
    check("coll_e1_hit", hit_mask[0], 1'b0);
    #1 spawn_valid = 1'b0;
    @(negedge clk);
    check("coll_e2_hit", hit_mask[0], 1'b1);
    check("coll_e2_player_hit", player_hit, 1'b0);
`ifdef ENEMY_KILL_ON_HIT_EN
    check("coll_e2_killed", enemy_active[0], 1'b0);
`else
    check("coll_e2_alive", enemy_active[0], 1'b1);
`endif
    @(negedge clk);
    check("coll_e3_player_hit", player_hit, 1'b1);
    #1 playerX = 8'd0; playerY = 7'd0;
    repeat (6) @(negedge clk);
    check("coll_sticky_hit", hit_mask[0], 1'b1);
    check("coll_sticky_player_hit", player_hit, 1'b1);
`ifdef ENEMY_KILL_ON_HIT_EN
    #1 set_spawn(10, 10, 1, 0, 0, 1'b0, 1'b0); spawn_valid = 1'b1;
    @(negedge clk);
    check("respawn_active", enemy_active[0], 1'b1);
    check("respawn_hit_clear", hit_mask[0], 1'b0);
    #1 spawn_valid = 1'b0;
`endif

    // Near miss: enemy at (83,100) just right of the player
    do_reset();
    playerX = 8'd80; playerY = 7'd100;
    set_spawn(83, 100, 2, 0, 0, 1'b0, 1'b0);
    play = 1'b1; spawn_valid = 1'b1;
    @(negedge clk);
    #1 spawn_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("miss_hit", hit_mask, '0);
    check("miss_player_hit", player_hit, 1'b0);

    // Randomized play with periodic mid-run resets
    for (int r = 0; r < 24; r++) begin
      do_reset();
      playerX = 8'($urandom_range(0, 159));
      playerY = 7'($urandom_range(0, 119));
      for (int c = 0; c < 200; c++) begin
        @(negedge clk);
        #1;
        play        = ($urandom_range(0, 7) != 0);
        spawn_valid = ($urandom_range(0, 2) == 0);
        set_spawn($urandom_range(0, 255), $urandom_range(0, 127), $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom_range(0, 7),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        if ($urandom_range(0, 3) == 0) begin
          playerX = 8'($urandom_range(0, 159));
          playerY = 7'($urandom_range(0, 119));
        end
      end
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/enemy_array_control.md
# enemy_array_control

Parametrised multi-enemy motion and collision engine for the game datapath. It holds up to `NUM_ENEMIES` square enemies in slots, each with its own size, slope and direction, and steps all of them together on a shared rate-divided tick. Each enemy bounces off the screen edges and is checked for overlap against the player. It sits between the spawn/level logic (spawn handshake) and the draw FSM (positions, active mask, redraw tick), next to `player_control`.

## Interface
- `NUM_ENEMIES`, 4: number of enemy slots, 1..8.
- `RATE_DIV`, 249999: a tick fires when the counter equals this value; the period is `RATE_DIV+1` cycles.
- `SCREEN_W`, 160: screen width in pixels.
- `SCREEN_H`, 120: screen height in pixels.
- `PLAYER_SIZE`, 3: side length of the square player in pixels.

- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `play`  in  1  game running. When low, all motion, spawning and collision are frozen.
- `playerX`  in  8  player top-left X.
- `playerY`  in  7  player top-left Y.
- `spawn_valid`  in  1  spawn request.
- `spawn_ready`  out  1  equals `play` AND (some slot is free). Combinational.
- `spawn_size`  in  3  enemy side length. A value of 0 is loaded as 1.
- `spawn_x`  in  8  start X.
- `spawn_y`  in  7  start Y.
- `spawn_dx`  in  3  X step per tick.
- `spawn_dy`  in  3  Y step per tick.
- `spawn_left`  in  1  initial X direction is left.
- `spawn_up`  in  1  initial Y direction is up.
- `enemy_active`  out  N  per-slot occupied flag.
- `enemyX`  out  8*N  slot i occupies bits [8i+7:8i].
- `enemyY`  out  7*N  slot i occupies bits [7i+6:7i].
- `tick`  out  1  one-cycle pulse, registered in the same cycle the positions update.
- `hit_mask`  out  N  sticky per-slot collision flags.
- `player_hit`  out  1  OR of `hit_mask`, registered.

## Operation
- **Reset values:** counter 0, `tick` 0, all `enemy_active` 0, all `enemyX`/`enemyY` 0, directions 0, `hit_mask` 0, `player_hit` 0.
- **Spawn:**
  - A spawn is accepted on a rising edge with `spawn_valid && spawn_ready`.
  - It loads the lowest-index inactive slot with the spawn values and sets that slot active.
  - It clears that slot's `hit_mask` bit.
  - Start coordinates are clamped to `SCREEN_W-size` and `SCREEN_H-size`.
- **Counter:**
  - Runs only while `play` is high; it holds its value while `play` is low.
  - On reaching `RATE_DIV` it wraps to 0 and asserts `tick` for one cycle.
- **Step on tick (all active slots in parallel):** all arithmetic uses 9-bit unsigned intermediates, so no wrap-around is possible.
  - Moving left: if `x <= dx`, set x=0 and switch direction to right; else x = x-dx.
  - Moving right: if `x+size+dx >= SCREEN_W`, set x = SCREEN_W-size and switch direction to left; else x = x+dx.
  - Y uses the same rules with `up`/`SCREEN_H`.
  - A slot with dx=0 (or dy=0) does not move on that axis and never flips on that axis.
- **Collision:**
  - Evaluated every cycle while `play` is high, for active slots only, on the current registered positions.
  - A slot overlaps the player when `playerX <= x+size-1`, `x <= playerX+PLAYER_SIZE-1`, and the same holds on Y.
  - On overlap the slot's `hit_mask` bit is set and stays set; it is cleared only by reset or a respawn of that slot.
- **Simultaneous events:**
  - If a spawn and a tick occur in the same cycle, the newly loaded slot takes its spawn values and does not step.
  - The other slots step normally.
- **Reset mid-operation:** reset takes effect immediately and asynchronously; any in-flight spawn is dropped.

## Timing
- Spawn-to-visible latency is 1 cycle: `enemy_active`/`enemyX`/`enemyY` update on the accepting edge.
- Tick-to-position latency is 0: positions and `tick` update on the same edge.
- Overlap-to-flag latency:
  - `hit_mask` is set 1 cycle after the registered positions overlap.
  - `player_hit` follows 1 cycle later, 2 cycles in total.
- `spawn_ready` is combinational from `enemy_active` and `play`. The spawner must not depend on it within the same cycle it drives `spawn_valid`.

## Configuration
- Macro `ENEMY_KILL_ON_HIT_EN`.
- **Defined:** on the edge that sets a slot's `hit_mask` bit, that slot's `enemy_active` is also cleared. The slot is then free for spawning on the next cycle, and `hit_mask` stays sticky.
- **Undefined:** colliding enemies remain active and keep moving.

## Test plan
All scenarios use `RATE_DIV`=3 and N=4.
- **Reset:** assert `reset` mid-run -> all outputs 0 immediately; after release, the first tick occurs 4 cycles after `play` goes high.
- **Fill slots:** spawn 5 times back-to-back with `spawn_valid` held high -> slots 0..3 fill on consecutive edges, then `spawn_ready` goes 0 and the 5th request stalls; with `play` low, `spawn_ready` is 0.
- **Left bounce:** spawn x=2, dx=3, left, size 2 -> after the 1st tick x=0 and direction is right; after the 2nd tick x=3.
- **Right bounce:** spawn x=155, dx=4, right, size 3 -> after the 1st tick x=157 and direction is left; after the 2nd tick x=153. Repeat on Y with y=116, dy=2, down, size 2 -> y=118, then 116.
- **Collision:** player at (80,100), spawn size 2 at (82,102) -> `hit_mask[0]` set 1 cycle later, `player_hit` 2 cycles later, both sticky. Spawning at (83,100) instead -> no hit.
- **Kill on hit:** with `ENEMY_KILL_ON_HIT_EN` defined, repeat the collision case -> `enemy_active[0]` clears on the same edge as `hit_mask[0]` sets. A new spawn then reuses slot 0 and clears `hit_mask[0]`.
